alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 32-bit integer ALU between two requesters (port 0: execute-stage integer path, port 1: branch/address-generation path) with valid/ready handshakes. Arbitrates, registers the winning operands onto the ALU inputs, captures the ALU result and flags, and holds the response until the winning requester accepts it. Sits between the requesters and the ALU, which it drives directly. One operation in flight at a time.

## Interface

- No parameters; data width fixed at 32, op width fixed at 4.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester n presents an operation
- req0_ready / req1_ready  out  1  requester n's operation accepted this cycle
- req0_op / req1_op  in  4  ALU opcode (aluop_t encoding, passed through unmodified)
- req0_a / req1_a  in  32  operand A
- req0_b / req1_b  in  32  operand B
- rsp0_valid / rsp1_valid  out  1  result available for requester n
- rsp0_ready / rsp1_ready  in  1  requester n accepts result
- rsp_result  out  32  captured ALUResult (shared by both response ports)
- rsp_negative  out  1  captured negative flag
- rsp_zero  out  1  captured zero flag
- alu_op  out  4  drives ALU ALUOp
- alu_a  out  32  drives ALU inputA
- alu_b  out  32  drives ALU inputB
- alu_result  in  32  from ALU ALUResult
- alu_negative  in  1  from ALU negative
- alu_zero  in  1  from ALU zero

## Operation

- FSM states: IDLE, EXEC, RESP. Registers: state, gnt (1 bit, owner of the in-flight op), last (1 bit, last port granted), alu_op/alu_a/alu_b, rsp_result/rsp_negative/rsp_zero.
- IDLE: if any reqN_valid, pick winner, assert reqN_ready for the winner only (combinational), latch op/a/b into alu_* registers, set gnt and last, go to EXEC. Otherwise stay.
- EXEC: ALU sees the registered operands; capture alu_result/alu_negative/alu_zero into rsp_* registers; go to RESP.
- RESP: assert rsp{gnt}_valid; hold rsp_* stable. On rsp{gnt}_ready, go to IDLE. The other port's rspN_valid stays 0.
- Arbitration (both valid): see Configuration. A single valid requester always wins.
- req*_ready is 0 in EXEC and RESP, and 0 whenever rst is high.
- Flags pass through unmodified. The ALU asserts zero only for SUB, so rsp_zero is 0 for every other opcode. Unknown opcodes pass through and return whatever the ALU produces.
- Reset values: state=IDLE, gnt=0, last=1, alu_op=0, alu_a=0, alu_b=0, rsp_result=0, rsp_negative=0, rsp_zero=0, all valid/ready outputs 0.
- Reset mid-operation: the in-flight op is discarded and no response is issued. The requester must re-issue.

## Timing

- Accept in cycle N (reqN_valid && reqN_ready). ALU evaluates in N+1. rspN_valid is high from N+2.
- Response handshake in cycle M: IDLE in M+1, so the next accept is no earlier than M+1. Peak throughput is one op per 3 cycles.
- rsp_* and alu_* outputs are registered and glitch-free. reqN_ready is combinational from valid inputs and state.
- Requesters hold valid/op/a/b until ready; the block samples operands only in the accept cycle.

## Configuration

- ALU_ARB_RR_EN defined: round-robin. When both are valid, the port opposite to `last` wins. Because last resets to 1, port 0 wins the first contest.
- ALU_ARB_RR_EN undefined: fixed priority. Port 0 always wins a contest. `last` is still maintained but ignored.

## Test plan

- Single op: reset, then req0 ADD a=5 b=7 -> req0_ready in the same cycle; rsp0_valid 2 cycles later with result=12, negative=0, zero=0; rsp1_valid stays 0.
- SUB flags: req1 SUB a=3 b=3 -> rsp_result=0, zero=1. Then SUB a=2 b=5 -> result=0xFFFFFFFD, negative=1, zero=0.
- Contention, RR enabled: both valid continuously with ADD -> grants alternate 0,1,0,1. RR disabled: port 0 wins every contest and port 1 starves while req0_valid is held.
- Back-pressure: hold rsp0_ready=0 for 5 cycles -> rsp0_valid and rsp_result stay stable, req*_ready stay 0; release -> IDLE next cycle, next accept that cycle.
- Reset mid-op: assert rst during EXEC -> next cycle all outputs at reset values, no rsp*_valid; a fresh request afterwards completes normally.
- Throughput: back-to-back req0 ops with rsp0_ready=1 -> exactly one accept every 3 cycles.

Source files
------------

// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// Module      : alu_arbiter
// Description : Shares one 32-bit integer ALU between two valid/ready
//               requesters. There is one operation in flight at a time, with
//               registered ALU operands and a registered response.
//               Optional feature macro: ALU_ARB_RR_EN. When it is defined,
//               contested requests are granted round-robin. When it is not
//               defined, port 0 has fixed priority.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    // requester 0: execute-stage integer path
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    // requester 1: branch/address-generation path
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    // responses
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_negative,
    output logic        rsp_zero,
    // shared ALU
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_negative,
    input  logic        alu_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_gnt;
    logic        r_last;
    logic [3:0]  r_alu_op;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [31:0] r_rsp_result;
    logic        r_rsp_negative;
    logic        r_rsp_zero;

    logic        w_any_valid;
    logic        w_contest_win;
    logic        w_win;
    logic        w_accept;
    logic        w_rsp_ack;

    assign w_any_valid = req0_valid | req1_valid;

`ifdef ALU_ARB_RR_EN
    // The port that did not win last time takes a contested cycle.
    assign w_contest_win = ~r_last;
`else
    // Port 0 always takes a contested cycle. last is tracked but has no effect.
    assign w_contest_win = r_last & 1'b0;
`endif

    // An uncontested requester always wins.
    assign w_win     = (req0_valid & req1_valid) ? w_contest_win : req1_valid;
    assign w_accept  = ~rst & (r_state == S_IDLE) & w_any_valid;
    assign w_rsp_ack = r_gnt ? rsp1_ready : rsp0_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        req0_ready = w_accept & ~w_win;
        req1_ready = w_accept &  w_win;
        rsp0_valid = (r_state == S_RESP) & ~r_gnt;
        rsp1_valid = (r_state == S_RESP) &  r_gnt;
    end

    // Operand launch on accept, result capture while the ALU evaluates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt          <= 1'b0;
            r_last         <= 1'b1;
            r_alu_op       <= 4'd0;
            r_alu_a        <= 32'd0;
            r_alu_b        <= 32'd0;
            r_rsp_result   <= 32'd0;
            r_rsp_negative <= 1'b0;
            r_rsp_zero     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gnt    <= w_win;
                r_last   <= w_win;
                r_alu_op <= w_win ? req1_op : req0_op;
                r_alu_a  <= w_win ? req1_a  : req0_a;
                r_alu_b  <= w_win ? req1_b  : req0_b;
            end
            if (r_state == S_EXEC) begin
                r_rsp_result   <= alu_result;
                r_rsp_negative <= alu_negative;
                r_rsp_zero     <= alu_zero;
            end
        end
    end

    assign alu_op       = r_alu_op;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign rsp_result   = r_rsp_result;
    assign rsp_negative = r_rsp_negative;
    assign rsp_zero     = r_rsp_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. It uses directed scenarios
//               plus randomized traffic, checked against a transaction-level
//               model. It honours ALU_ARB_RR_EN in the same way as the design.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_alu_arbiter;

    localparam logic [3:0] C_OP_ADD = 4'd0;
    localparam logic [3:0] C_OP_SUB = 4'd1;
`ifdef ALU_ARB_RR_EN
    localparam bit C_RR = 1'b1;
`else
    localparam bit C_RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_negative, rsp_zero;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_negative, alu_zero;

    always #5 clk = ~clk;

    alu_arbiter u_dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op      (req0_op),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op      (req1_op),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .rsp0_valid   (rsp0_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp1_valid   (rsp1_valid),
        .rsp1_ready   (rsp1_ready),
        .rsp_result   (rsp_result),
        .rsp_negative (rsp_negative),
        .rsp_zero     (rsp_zero),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_negative (alu_negative),
        .alu_zero     (alu_zero)
    );

    // Behavioural ALU, returned as {negative, zero, result}. Only SUB ever flags zero.
    function automatic logic [33:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            default: r = {a[15:0], b[15:0]};
        endcase
        return {r[31], (op == C_OP_SUB) && (r == 32'd0), r};
    endfunction

    always_comb {alu_negative, alu_zero, alu_result} = alu_f(alu_op, alu_a, alu_b);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Transaction-level model: accept time, owner and latched operands/result
    bit          m_busy  = 1'b0;
    bit          m_owner = 1'b0;
    bit          m_last  = 1'b1;
    int          m_acc   = 0;
    int          cyc     = 0;
    logic [3:0]  m_op    = 4'd0;
    logic [31:0] m_a     = 32'd0;
    logic [31:0] m_b     = 32'd0;
    logic [31:0] m_res   = 32'd0;
    logic        m_neg   = 1'b0;
    logic        m_zero  = 1'b0;
    bit          auto_drop = 1'b1;
    int          grants[$];
    int          acc_cyc[$];

    // One clock cycle: check outputs before the edge, advance the model on the edge
    task automatic tick();
        bit w, e_r0, e_r1, e_v0, e_v1, drop0, drop1;
        drop0 = 1'b0;
        drop1 = 1'b0;
        #2;
        if (req0_valid && req1_valid) w = C_RR ? ~m_last : 1'b0;
        else                          w = req1_valid;
        e_r0 = !rst && !m_busy && req0_valid && !w;
        e_r1 = !rst && !m_busy && req1_valid &&  w;
        e_v0 = m_busy && !m_owner && (cyc >= m_acc + 2);
        e_v1 = m_busy &&  m_owner && (cyc >= m_acc + 2);
        check_eq("req0_ready",   32'(req0_ready),   32'(e_r0));
        check_eq("req1_ready",   32'(req1_ready),   32'(e_r1));
        check_eq("rsp0_valid",   32'(rsp0_valid),   32'(e_v0));
        check_eq("rsp1_valid",   32'(rsp1_valid),   32'(e_v1));
        check_eq("alu_op",       32'(alu_op),       32'(m_op));
        check_eq("alu_a",        alu_a,             m_a);
        check_eq("alu_b",        alu_b,             m_b);
        check_eq("rsp_result",   rsp_result,        m_res);
        check_eq("rsp_negative", 32'(rsp_negative), 32'(m_neg));
        check_eq("rsp_zero",     32'(rsp_zero),     32'(m_zero));
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0; m_last = 1'b1;
            m_op = 4'd0; m_a = 32'd0; m_b = 32'd0;
            m_res = 32'd0; m_neg = 1'b0; m_zero = 1'b0;
        end else if (e_r0 || e_r1) begin
            m_busy = 1'b1; m_owner = e_r1; m_acc = cyc; m_last = e_r1;
            m_op = e_r1 ? req1_op : req0_op;
            m_a  = e_r1 ? req1_a  : req0_a;
            m_b  = e_r1 ? req1_b  : req0_b;
            grants.push_back(int'(e_r1));
            acc_cyc.push_back(cyc);
            drop0 = auto_drop && e_r0;
            drop1 = auto_drop && e_r1;
        end else if (m_busy && cyc == m_acc + 1) begin
            {m_neg, m_zero, m_res} = alu_f(m_op, m_a, m_b);
        end else if ((e_v0 && rsp0_ready) || (e_v1 && rsp1_ready)) begin
            m_busy = 1'b0;
        end
        cyc++;
        #1;
        if (drop0) req0_valid = 1'b0;
        if (drop1) req1_valid = 1'b0;
    endtask

    task automatic drain();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b0; req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        @(posedge clk); #1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Single ADD on port 0, response held until checked
        req0_valid = 1'b1; req0_op = C_OP_ADD; req0_a = 32'd5; req0_b = 32'd7;
        tick(); tick();
        check_eq("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check_eq("add_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check_eq("add_result",     rsp_result,      32'd12);
        check_eq("add_flags",      32'({rsp_negative, rsp_zero}), 32'd0);
        rsp0_ready = 1'b1;
        tick();

        // SUB flag cases on port 1
        req1_valid = 1'b1; req1_op = C_OP_SUB; req1_a = 32'd3; req1_b = 32'd3;
        tick(); tick();
        check_eq("sub_eq_result", rsp_result,    32'd0);
        check_eq("sub_eq_zero",   32'(rsp_zero), 32'd1);
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_op = C_OP_SUB; req1_a = 32'd2; req1_b = 32'd5;
        tick(); tick();
        check_eq("sub_neg_result", rsp_result,        32'hFFFF_FFFD);
        check_eq("sub_neg_flag",   32'(rsp_negative), 32'd1);
        check_eq("sub_neg_zero",   32'(rsp_zero),     32'd0);
        drain();

        // Contention: both held valid, responses accepted at once
        auto_drop = 1'b0;
        grants.delete(); acc_cyc.delete();
        req0_valid = 1'b1; req0_op = C_OP_ADD; req0_a = 32'd10; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = C_OP_ADD; req1_a = 32'd20; req1_b = 32'd2;
        repeat (13) tick();
        check_eq("contest_count", 32'(grants.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check_eq($sformatf("contest_grant%0d", i), 32'(grants[i]), C_RR ? 32'(i % 2) : 32'd0);
        for (int i = 0; i < 3 && i + 1 < acc_cyc.size(); i++)
            check_eq($sformatf("throughput%0d", i), 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd3);
        auto_drop = 1'b1;
        drain();

        // Back-pressure on port 0 while port 1 waits
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_op = C_OP_ADD; req0_a = 32'd100; req0_b = 32'd23;
        tick();
        req1_valid = 1'b1; req1_op = C_OP_ADD; req1_a = 32'd1; req1_b = 32'd1;
        repeat (6) tick();
        check_eq("bp_hold_valid",  32'(rsp0_valid), 32'd1);
        check_eq("bp_hold_result", rsp_result,      32'd123);
        check_eq("bp_hold_ready1", 32'(req1_ready), 32'd0);
        rsp0_ready = 1'b1;
        tick();
        check_eq("bp_next_accept", 32'(req1_ready), 32'd1);
        drain();

        // Reset during EXEC discards the op
        req0_valid = 1'b1; req0_op = C_OP_SUB; req0_a = 32'd9; req0_b = 32'd4;
        rsp0_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check_eq("rst_alu_a",      alu_a,           32'd0);
        check_eq("rst_last_op",    32'(alu_op),     32'd0);
        repeat (2) tick();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_op = C_OP_ADD; req0_a = 32'd40; req0_b = 32'd2;
        tick(); tick();
        check_eq("rst_fresh_valid",  32'(rsp0_valid), 32'd1);
        check_eq("rst_fresh_result", rsp_result,      32'd42);
        drain();

        // Randomized traffic with occasional reset
        for (int n = 0; n < 1500; n++) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1;
                req0_op = 4'($urandom_range(0, 7));
                req0_a = $urandom;
                req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1;
                req1_op = 4'($urandom_range(0, 7));
                req1_a = $urandom;
                req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
            end
            rsp0_ready = ($urandom_range(0, 9) < 7);
            rsp1_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 79) == 0);
            tick();
        end
        rst = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
